// File: rtl/bus_timer.sv
// ---------------------------------------------------------------------------
// bus_timer
// Memory-mapped programmable down-counter timer on the CPU data-memory bus.
// Five-register window at BASE_ADDR:
//   +0 CTRL     (R/W)  bit0 EN, bit1 AUTO
//   +1 LOAD     (R/W)  reload value
//   +2 COUNT    (RO)   current count
//   +3 STATUS   (W1C)  bit0 DONE
//   +4 PRESCALE (R/W)  count steps once per PRESCALE+1 clocks
// Reads are combinational with no side effects. read_drive tells the top
// level when to put read_data onto the shared bus.
// ---------------------------------------------------------------------------
module bus_timer #(
    parameter logic [8:0] BASE_ADDR  = 9'h180,
    parameter int         DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            mem_cmd,
    input  logic [8:0]            mem_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_drive,
    output logic                  tick,
    output logic                  done
);

    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    localparam logic [8:0] OFS_CTRL     = 9'd0;
    localparam logic [8:0] OFS_LOAD     = 9'd1;
    localparam logic [8:0] OFS_COUNT    = 9'd2;
    localparam logic [8:0] OFS_STATUS   = 9'd3;
    localparam logic [8:0] OFS_PRESCALE = 9'd4;

    localparam logic [DATA_WIDTH-1:0] ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_EXPIRED = 2'b10
    } state_t;

    // Architectural state
    state_t                state_r;
    logic                  en_r;
    logic                  auto_r;
    logic [DATA_WIDTH-1:0] load_r;
    logic [DATA_WIDTH-1:0] count_r;
    logic [DATA_WIDTH-1:0] prescale_r;
    logic [DATA_WIDTH-1:0] presc_cnt_r;
    logic                  done_r;
    logic                  tick_r;

    // Decode and control strobes
    logic [8:0]            offset_s;
    logic                  hit_s;
    logic                  wr_s;
    logic                  wr_ctrl_s;
    logic                  wr_load_s;
    logic                  wr_status_s;
    logic                  wr_presc_s;
    logic                  stop_req_s;
    logic                  start_req_s;
    logic                  presc_wrap_s;
    logic                  step_s;
    logic                  expire_s;
    logic                  eff_auto_s;
    logic [DATA_WIDTH-1:0] read_mux_s;

    // Offset is taken modulo the 9-bit address space so a single compare
    // covers the whole window.
    assign offset_s = mem_addr - BASE_ADDR;

    // Address decode and per-register write strobes.
    always_comb begin
        hit_s       = 1'b0;
        wr_s        = 1'b0;
        wr_ctrl_s   = 1'b0;
        wr_load_s   = 1'b0;
        wr_status_s = 1'b0;
        wr_presc_s  = 1'b0;
        if (offset_s <= OFS_PRESCALE) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
        if (hit_s && (mem_cmd == CMD_WRITE)) begin
            wr_s = 1'b1;
        end else begin
            wr_s = 1'b0;
        end
        case (offset_s)
            OFS_CTRL:     wr_ctrl_s   = wr_s;
            OFS_LOAD:     wr_load_s   = wr_s;
            OFS_STATUS:   wr_status_s = wr_s;
            OFS_PRESCALE: wr_presc_s  = wr_s;
            default: begin
                wr_ctrl_s   = 1'b0;
                wr_load_s   = 1'b0;
                wr_status_s = 1'b0;
                wr_presc_s  = 1'b0;
            end
        endcase
    end

    // Timer step/expiry qualification. A CTRL write clearing EN beats any
    // step on the same edge, so expiry is masked by stop_req_s. The prescaler
    // compare uses >= so a counter left above a freshly lowered PRESCALE
    // wraps on the very next clock.
    always_comb begin
        stop_req_s   = wr_ctrl_s & ~write_data[0];
        start_req_s  = wr_ctrl_s &  write_data[0];
        presc_wrap_s = (presc_cnt_r >= prescale_r);
        if ((state_r == ST_RUN) && presc_wrap_s && !stop_req_s) begin
            step_s = 1'b1;
        end else begin
            step_s = 1'b0;
        end
        if (step_s && (count_r == ZERO)) begin
            expire_s = 1'b1;
        end else begin
            expire_s = 1'b0;
        end
        if (wr_ctrl_s) begin
            eff_auto_s = write_data[1];
        end else begin
            eff_auto_s = auto_r;
        end
    end

    // Control FSM with all timer registers and registered tick/done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            en_r        <= 1'b0;
            auto_r      <= 1'b0;
            load_r      <= ZERO;
            count_r     <= ZERO;
            prescale_r  <= ZERO;
            presc_cnt_r <= ZERO;
            done_r      <= 1'b0;
            tick_r      <= 1'b0;
        end else begin
            tick_r <= 1'b0;

            if (wr_load_s) begin
                load_r <= write_data;
            end
            if (wr_presc_s) begin
                prescale_r <= write_data;
            end
            if (wr_ctrl_s) begin
                en_r   <= write_data[0];
                auto_r <= write_data[1];
            end

            // Expiry setting DONE wins over a simultaneous write-1-to-clear.
            if (expire_s) begin
                done_r <= 1'b1;
            end else if (wr_status_s && write_data[0]) begin
                done_r <= 1'b0;
            end

            case (state_r)
                ST_IDLE, ST_EXPIRED: begin
                    if (start_req_s) begin
                        state_r     <= ST_RUN;
                        count_r     <= load_r;
                        presc_cnt_r <= ZERO;
                    end
                end
                ST_RUN: begin
                    if (stop_req_s) begin
                        // Count and prescaler freeze where they are.
                        state_r <= ST_IDLE;
                    end else if (presc_wrap_s) begin
                        presc_cnt_r <= ZERO;
                        if (count_r == ZERO) begin
                            tick_r <= 1'b1;
                            if (eff_auto_s) begin
                                count_r <= load_r;
                            end else begin
                                en_r    <= 1'b0;
                                state_r <= ST_EXPIRED;
                            end
                        end else begin
                            count_r <= count_r - ONE;
                        end
                    end else begin
                        presc_cnt_r <= presc_cnt_r + ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Zero-latency read mux; unused CTRL/STATUS bits read as zero.
    always_comb begin
        read_mux_s = ZERO;
        case (offset_s)
            OFS_CTRL:     read_mux_s = {{(DATA_WIDTH-2){1'b0}}, auto_r, en_r};
            OFS_LOAD:     read_mux_s = load_r;
            OFS_COUNT:    read_mux_s = count_r;
            OFS_STATUS:   read_mux_s = {{(DATA_WIDTH-1){1'b0}}, done_r};
            OFS_PRESCALE: read_mux_s = prescale_r;
            default:      read_mux_s = ZERO;
        endcase
    end

    // Bus drive is suppressed while reset is held so the block never
    // fights other read sources during reset.
    always_comb begin
        if (hit_s && (mem_cmd == CMD_READ) && reset) begin
            read_drive = 1'b1;
            read_data  = read_mux_s;
        end else begin
            read_drive = 1'b0;
            read_data  = ZERO;
        end
    end

    assign tick = tick_r;
    assign done = done_r;

    // Flag the otherwise write-only use of en_r for observability: en_r is
    // read back through CTRL above, so no further logic is needed here.

endmodule

// File: tb/tb_bus_timer.sv
// ---------------------------------------------------------------------------
// tb_bus_timer
// Self-checking bench for bus_timer. Expected counts and tick instants come
// from closed-form arithmetic on LOAD, PRESCALE and elapsed clocks.
// ---------------------------------------------------------------------------
module tb_bus_timer;

    localparam logic [8:0] A_CTRL   = 9'h180;
    localparam logic [8:0] A_LOAD   = 9'h181;
    localparam logic [8:0] A_COUNT  = 9'h182;
    localparam logic [8:0] A_STATUS = 9'h183;
    localparam logic [8:0] A_PRESC  = 9'h184;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        read_drive;
    logic        tick;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    bus_timer #(.BASE_ADDR(9'h180), .DATA_WIDTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .read_drive (read_drive),
        .tick       (tick),
        .done       (done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int period_of(input int l, input int p);
        return (l + 1) * (p + 1);
    endfunction

    // Count seen t clocks after the start edge.
    function automatic int exp_count(input int l, input int p, input bit au, input int t);
        int per;
        int tt;
        per = period_of(l, p);
        if (!au && t >= per) return 0;
        tt = t % per;
        return l - (tt / (p + 1));
    endfunction

    // Tick visible t clocks after the start edge.
    function automatic bit exp_tick(input int l, input int p, input bit au, input int t);
        int per;
        per = period_of(l, p);
        if (t <= 0) return 1'b0;
        if (au) return (t % per) == 0;
        return t == per;
    endfunction

    // ---------------- bus helpers ----------------
    task automatic wr(input logic [8:0] a, input logic [15:0] d);
        @(negedge clk);
        mem_cmd = 2'b10; mem_addr = a; write_data = d;
        @(posedge clk);
        #1;
        mem_cmd = 2'b00; mem_addr = 9'h000; write_data = 16'h0000;
    endtask

    task automatic rd(input logic [8:0] a, output logic [15:0] d, output logic drv);
        mem_cmd = 2'b01; mem_addr = a;
        #1;
        d = read_data; drv = read_drive;
        mem_cmd = 2'b00; mem_addr = 9'h000;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [15:0] d;
        logic        drv;
        reset = 1'b0; mem_cmd = 2'b00; mem_addr = 9'h000; write_data = 16'h0000;
        #2;
        rd(A_CTRL, d, drv);
        n_cmp++; if (drv !== 1'b0) begin n_err++; $display("FAIL rst_drive_in_reset: got %0b expected 0", drv); end
        n_cmp++; if (tick !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rst_outputs: got tick=%0b done=%0b expected 0/0", tick, done); end
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            rd(9'h180 + 9'(i), d, drv);
            n_cmp++; if (d !== 16'h0000 || drv !== 1'b1) begin n_err++; $display("FAIL rst_read_%0d: got data=%h drive=%0b expected 0000/1", i, d, drv); end
        end
        rd(9'h185, d, drv);
        n_cmp++; if (drv !== 1'b0 || d !== 16'h0000) begin n_err++; $display("FAIL miss_185: got data=%h drive=%0b expected 0000/0", d, drv); end
        rd(9'h140, d, drv);
        n_cmp++; if (drv !== 1'b0 || d !== 16'h0000) begin n_err++; $display("FAIL miss_140: got data=%h drive=%0b expected 0000/0", d, drv); end
        // COUNT is read-only
        wr(A_COUNT, 16'h1234);
        rd(A_COUNT, d, drv);
        n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL count_ro: got %h expected 0000", d); end
        // Command 2'b11 must not write
        @(negedge clk); mem_cmd = 2'b11; mem_addr = A_LOAD; write_data = 16'hBEEF;
        @(posedge clk); #1; mem_cmd = 2'b00;
        rd(A_LOAD, d, drv);
        n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL cmd11_ignored: got %h expected 0000", d); end
        // Writes outside the window must not alias into LOAD
        wr(9'h101, 16'h00AA);
        rd(A_LOAD, d, drv);
        n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL outside_ignored: got %h expected 0000", d); end
    endtask

    task automatic test_one_shot();
        logic [15:0] d;
        logic        drv;
        int          ticks = 0;
        wr(A_LOAD, 16'd3);
        wr(A_PRESC, 16'd0);
        wr(A_CTRL, 16'h0001);
        for (int t = 1; t <= 8; t++) begin
            @(posedge clk); #1;
            if (tick === 1'b1) ticks++;
            n_cmp++; if (tick !== exp_tick(3, 0, 1'b0, t)) begin n_err++; $display("FAIL oneshot_tick t=%0d: got %0b expected %0b", t, tick, exp_tick(3, 0, 1'b0, t)); end
            rd(A_COUNT, d, drv);
            n_cmp++; if (d !== 16'(exp_count(3, 0, 1'b0, t))) begin n_err++; $display("FAIL oneshot_count t=%0d: got %0d expected %0d", t, d, exp_count(3, 0, 1'b0, t)); end
        end
        n_cmp++; if (ticks != 1) begin n_err++; $display("FAIL oneshot_nticks: got %0d expected 1", ticks); end
        rd(A_STATUS, d, drv);
        n_cmp++; if (d !== 16'h0001 || done !== 1'b1) begin n_err++; $display("FAIL oneshot_status: got %h done=%0b expected 0001/1", d, done); end
        rd(A_CTRL, d, drv);
        n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL oneshot_ctrl: got %h expected 0000", d); end
    endtask

    task automatic test_auto_reload();
        logic [15:0] d;
        logic        drv;
        int          ticks = 0;
        wr(A_LOAD, 16'd1);
        wr(A_PRESC, 16'd2);
        wr(A_CTRL, 16'h0003);
        for (int t = 1; t <= 30; t++) begin
            @(posedge clk); #1;
            if (tick === 1'b1) ticks++;
            n_cmp++; if (tick !== exp_tick(1, 2, 1'b1, t)) begin n_err++; $display("FAIL auto_tick t=%0d: got %0b expected %0b", t, tick, exp_tick(1, 2, 1'b1, t)); end
            rd(A_COUNT, d, drv);
            n_cmp++; if (d !== 16'(exp_count(1, 2, 1'b1, t))) begin n_err++; $display("FAIL auto_count t=%0d: got %0d expected %0d", t, d, exp_count(1, 2, 1'b1, t)); end
        end
        n_cmp++; if (ticks != 5) begin n_err++; $display("FAIL auto_nticks: got %0d expected 5", ticks); end
        rd(A_CTRL, d, drv);
        n_cmp++; if (d !== 16'h0003) begin n_err++; $display("FAIL auto_ctrl: got %h expected 0003", d); end
        wr(A_CTRL, 16'h0000);
    endtask

    task automatic test_w1c_priority();
        logic [15:0] d;
        logic        drv;
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL w1c_pre: got %0b expected 1", done); end
        wr(A_STATUS, 16'h0000);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL w1c_zero_write: got %0b expected 1", done); end
        wr(A_STATUS, 16'h0001);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL w1c_clear: got %0b expected 0", done); end
        rd(A_STATUS, d, drv);
        n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL w1c_status_read: got %h expected 0000", d); end
        // Clear lands exactly on the expiry edge (LOAD=2, PRESCALE=0 -> edge 3)
        wr(A_LOAD, 16'd2);
        wr(A_PRESC, 16'd0);
        wr(A_CTRL, 16'h0001);
        repeat (2) @(posedge clk);
        wr(A_STATUS, 16'h0001);
        n_cmp++; if (tick !== 1'b1 || done !== 1'b1) begin n_err++; $display("FAIL w1c_set_wins: got tick=%0b done=%0b expected 1/1", tick, done); end
        @(posedge clk); #1;
        n_cmp++; if (tick !== 1'b0 || done !== 1'b1) begin n_err++; $display("FAIL w1c_after: got tick=%0b done=%0b expected 0/1", tick, done); end
    endtask

    task automatic test_stop_restart();
        logic [15:0] d;
        logic        drv;
        wr(A_LOAD, 16'd10);
        wr(A_CTRL, 16'h0001);
        repeat (4) @(posedge clk);
        wr(A_CTRL, 16'h0000);
        rd(A_COUNT, d, drv);
        n_cmp++; if (d !== 16'd6) begin n_err++; $display("FAIL stop_count: got %0d expected 6", d); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            rd(A_COUNT, d, drv);
            n_cmp++; if (d !== 16'd6 || tick !== 1'b0) begin n_err++; $display("FAIL stop_hold %0d: got count=%0d tick=%0b expected 6/0", i, d, tick); end
        end
        wr(A_CTRL, 16'h0001);
        rd(A_COUNT, d, drv);
        n_cmp++; if (d !== 16'd10) begin n_err++; $display("FAIL restart_count: got %0d expected 10", d); end
        // Simultaneous expiry and stop: LOAD=0 expires every clock
        wr(A_CTRL, 16'h0000);
        wr(A_STATUS, 16'h0001);
        wr(A_LOAD, 16'd0);
        wr(A_CTRL, 16'h0003);
        wr(A_CTRL, 16'h0000);
        n_cmp++; if (tick !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL stop_beats_expiry: got tick=%0b done=%0b expected 0/0", tick, done); end
        wr(A_CTRL, 16'h0001);
        @(posedge clk); #1;
        n_cmp++; if (tick !== 1'b1 || done !== 1'b1) begin n_err++; $display("FAIL load0_expiry: got tick=%0b done=%0b expected 1/1", tick, done); end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] d;
        logic        drv;
        wr(A_LOAD, 16'd8);
        wr(A_CTRL, 16'h0001);
        repeat (3) @(posedge clk);
        #1;
        rd(A_COUNT, d, drv);
        n_cmp++; if (d !== 16'd5) begin n_err++; $display("FAIL mid_count: got %0d expected 5", d); end
        reset = 1'b0;
        #1;
        n_cmp++; if (tick !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL mid_reset_outputs: got tick=%0b done=%0b expected 0/0", tick, done); end
        @(posedge clk);
        @(negedge clk); reset = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            rd(9'h180 + 9'(i), d, drv);
            n_cmp++; if (d !== 16'h0000 || drv !== 1'b1) begin n_err++; $display("FAIL mid_read_%0d: got data=%h drive=%0b expected 0000/1", i, d, drv); end
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            rd(A_COUNT, d, drv);
            n_cmp++; if (tick !== 1'b0 || d !== 16'h0000) begin n_err++; $display("FAIL mid_idle %0d: got tick=%0b count=%0d expected 0/0", i, tick, d); end
        end
    endtask

    task automatic test_random();
        logic [15:0] d;
        logic        drv;
        int          l, p, per, span;
        bit          au;
        for (int it = 0; it < 8; it++) begin
            l  = $urandom_range(0, 5);
            p  = $urandom_range(0, 3);
            au = 1'($urandom_range(0, 1));
            per  = period_of(l, p);
            span = 3 * per + 2;
            wr(A_STATUS, 16'h0001);
            wr(A_LOAD, 16'(l));
            wr(A_PRESC, 16'(p));
            wr(A_CTRL, {14'h0000, au, 1'b1});
            for (int t = 1; t <= span; t++) begin
                @(posedge clk); #1;
                n_cmp++; if (tick !== exp_tick(l, p, au, t)) begin n_err++; $display("FAIL rnd_tick l=%0d p=%0d a=%0b t=%0d: got %0b expected %0b", l, p, au, t, tick, exp_tick(l, p, au, t)); end
                rd(A_COUNT, d, drv);
                n_cmp++; if (d !== 16'(exp_count(l, p, au, t))) begin n_err++; $display("FAIL rnd_count l=%0d p=%0d a=%0b t=%0d: got %0d expected %0d", l, p, au, t, d, exp_count(l, p, au, t)); end
            end
            rd(A_CTRL, d, drv);
            n_cmp++; if (d !== (au ? 16'h0003 : 16'h0000)) begin n_err++; $display("FAIL rnd_ctrl: got %h expected %h", d, (au ? 16'h0003 : 16'h0000)); end
            rd(A_STATUS, d, drv);
            n_cmp++; if (d !== 16'h0001) begin n_err++; $display("FAIL rnd_status: got %h expected 0001", d); end
            wr(A_CTRL, 16'h0000);
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_w1c_priority();
        test_stop_restart();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bus_timer.md
Name: bus_timer

Overview:
- Memory-mapped programmable down-counter timer peripheral on the CPU data-memory bus (mem_cmd, mem_addr, write_data, read_data), beside the RAM, the switch input port (0x140) and the LED output port (0x100).
- Gives CPU programs a cycle-accurate delay/periodic tick source.
- Decodes its own address window and produces read data plus a drive enable; the top level builds the tri-state onto read_data.

Parameters:
BASE_ADDR, 9'h180, first address of the 5-register window (0x180–0x184)
DATA_WIDTH, 16, bus data width and width of every timer register

Ports:
clk  input  1  rising-edge system clock
reset  input  1  asynchronous, active-low reset (0 = reset)
mem_cmd  input  2  bus command: 2'b00 NONE, 2'b01 READ, 2'b10 WRITE
mem_addr  input  9  bus address
write_data  input  16  CPU store data
read_data  output  16  register read value, combinational
read_drive  output  1  high when this block owns read_data this cycle
tick  output  1  one-cycle pulse on every expiry
done  output  1  sticky DONE flag, for an LED

Behaviour:
- Register map (offset from BASE_ADDR):
  - +0 CTRL, R/W: bit0 EN, bit1 AUTO; other bits read 0.
  - +1 LOAD, R/W: reload value.
  - +2 COUNT, read-only: current count; writes ignored.
  - +3 STATUS: bit0 DONE; write-1-to-clear; other bits read 0.
  - +4 PRESCALE, R/W: divider; count steps once per PRESCALE+1 clocks.
- Decode: hit = (mem_addr in BASE_ADDR..BASE_ADDR+4).
  - read_drive = hit & (mem_cmd==READ).
  - read_data = selected register when read_drive, else 16'h0000.
  - Reads have zero latency and no side effects.
- Writes: committed on the rising clk edge where mem_cmd==WRITE and hit. Addresses outside the window, and mem_cmd 2'b11, have no effect.
- Reset (reset=0, async): CTRL=0, LOAD=0, COUNT=0, STATUS=0, PRESCALE=0, prescaler counter=0, state=IDLE, tick=0, done=0, read_drive=0.
- FSM states: IDLE, RUN, EXPIRED.
  - IDLE/EXPIRED -> RUN: on a CTRL write with EN=1. Same edge: COUNT<=LOAD, prescaler<=0.
  - RUN: prescaler counts 0..PRESCALE. When it wraps to 0, a step occurs.
    - Step with COUNT!=0: COUNT<=COUNT-1.
    - Step with COUNT==0: expiry.
  - Expiry: DONE<=1; tick=1 for exactly the following cycle.
    - AUTO=1: COUNT<=LOAD, stay in RUN.
    - AUTO=0: EN<=0, go to EXPIRED, COUNT holds 0.
  - RUN -> IDLE: on a CTRL write with EN=0. COUNT and prescaler freeze; a later EN=1 write restarts from LOAD.
  - CTRL write with EN=1 while already in RUN: updates AUTO only, no restart.
- Timing: from the EN=1 write edge, the first expiry occurs (LOAD+1)*(PRESCALE+1) clocks later. The auto-reload period is (LOAD+1)*(PRESCALE+1) clocks.
- LOAD written during RUN: the current count is unaffected; the new value is used at the next reload or start.
- PRESCALE written during RUN: takes effect immediately. The prescaler counter is not reset; if it is above the new PRESCALE, it wraps at the next clock.
- Simultaneous expiry and a STATUS W1C on the same edge: set wins, DONE stays 1.
- Simultaneous expiry and a CTRL EN=0 write: the write wins. State goes to IDLE, no DONE set, no tick.
- COUNT arithmetic: unsigned, 16 bits. Never underflows; 0 triggers expiry instead of a decrement.
- done = STATUS.DONE, registered.
- Reset asserted mid-count: everything returns to reset values immediately. No tick on deassertion.

Test Plan:
- Reset, then read each offset 0x180–0x184 -> read_data=0x0000 and read_drive=1. Read 0x185 and 0x140 -> read_drive=0.
- One-shot: write LOAD=3, PRESCALE=0, CTRL=0x0001. Expect:
  - tick exactly once, 4 clocks after the write edge;
  - STATUS reads 0x0001 and done=1;
  - CTRL reads 0x0000 and COUNT reads 0.
- Auto-reload: write LOAD=1, PRESCALE=2, CTRL=0x0003 -> tick pulses every 6 clocks for 5 consecutive periods; COUNT sequence 1,1,1,0,0,0 repeats.
- W1C and priority:
  - After DONE=1, write STATUS=0x0001 -> done=0.
  - Issue the same write on the exact expiry edge -> done stays 1.
  - Write STATUS=0x0000 -> no change.
- Stop/restart: write LOAD=10, start, stop with CTRL=0 after 4 clocks -> COUNT holds 6, no tick. Restart with CTRL=1 -> COUNT reloads 10.
- Assert reset for 1 cycle mid-RUN with COUNT=5 -> all registers 0 immediately, tick stays 0 and state is IDLE after release.
